periph_bus_arbiter: RTL and testbench

Two-master arbiter in front of the peripheral block's single OBI-style data port (req/gnt/rvalid). It lets the CPU data port (master 0) and a second requester such as a DMA engine or debug module (master 1) share the port. Arbitration is round-robin, with one outstanding transaction at a time, matching the peripheral block's single-response tracking. Each response, including data and error, is routed back to the master that issued the request.

---
 rtl/periph_bus_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin arbiter in front of a single
// OBI-style peripheral data port, with one outstanding transaction at a time.
// Responses (data and error) are routed back to the master that issued them.
// Optional feature macro: PERIPH_BUS_ARB_TIMEOUT_EN. When it is defined, a
// grant that does not arrive within TIMEOUT_CYCLES REQ cycles is aborted and
// the owner receives an error response.
module periph_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic        s_err
);

    // Reject illegal timeout settings at elaboration time.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("periph_bus_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_TERR = 2'd3
    } state_t;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_tcnt;
    logic [7:0] w_tcnt_nxt;
    logic       w_tmo_hit;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;
`endif

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   w_owner_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   w_any_req;
    logic   w_win;
    logic   w_own_req;
    logic   w_gnt;

    // Round-robin choice: a lone requester wins, a tie goes to the master not granted last.
    assign w_any_req = m0_req | m1_req;
    assign w_win     = (m0_req & m1_req) ? ~r_last : m1_req;
    assign w_own_req = r_owner ? m1_req : m0_req;

`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
    assign w_tmo_hit = (r_state == ST_REQ) && (r_tcnt == TMO_LAST) && !s_gnt;
    assign w_gnt     = w_own_req & (s_gnt | w_tmo_hit);
`else
    assign w_gnt     = w_own_req & s_gnt;
`endif

    // State, owner and last-granted registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
            r_tcnt  <= 8'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
            r_tcnt  <= w_tcnt_nxt;
`endif
        end
    end

    // Next-state logic: arbitrate in IDLE or when a response completes, track grant in REQ.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
        w_tcnt_nxt  = r_tcnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_REQ;
                    w_owner_nxt = w_win;
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
                    w_tcnt_nxt  = 8'd0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!w_own_req) begin
                    // Owner withdrew before grant: abandon without touching last.
                    w_state_nxt = ST_IDLE;
                end else if (s_gnt) begin
                    w_state_nxt = ST_RESP;
                    w_last_nxt  = r_owner;
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_TERR;
                    w_last_nxt  = r_owner;
                end else begin
                    w_tcnt_nxt  = r_tcnt + 8'd1;
                end
`else
                end else begin
                    w_state_nxt = ST_REQ;
                end
`endif
            end
            ST_RESP: begin
                if (s_rvalid && w_any_req) begin
                    w_state_nxt = ST_REQ;
                    w_owner_nxt = w_win;
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
                    w_tcnt_nxt  = 8'd0;
`endif
                end else if (s_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
            ST_TERR: begin
                if (w_any_req) begin
                    w_state_nxt = ST_REQ;
                    w_owner_nxt = w_win;
                    w_tcnt_nxt  = 8'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output steering: forward the owner's request in REQ, route the response back in RESP/TERR.
    always_comb begin
        m0_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m0_rdata  = 32'h0000_0000;
        m0_err    = 1'b0;
        m1_gnt    = 1'b0;
        m1_rvalid = 1'b0;
        m1_rdata  = 32'h0000_0000;
        m1_err    = 1'b0;
        s_req     = 1'b0;
        s_we      = 1'b0;
        s_be      = 4'b0000;
        s_addr    = 32'h0000_0000;
        s_wdata   = 32'h0000_0000;
        if (rst) begin
            case (r_state)
                ST_REQ: begin
                    if (w_own_req) begin
                        s_req   = 1'b1;
                        s_we    = r_owner ? m1_we    : m0_we;
                        s_be    = r_owner ? m1_be    : m0_be;
                        s_addr  = r_owner ? m1_addr  : m0_addr;
                        s_wdata = r_owner ? m1_wdata : m0_wdata;
                    end else begin
                        s_req   = 1'b0;
                    end
                    m0_gnt = w_gnt & ~r_owner;
                    m1_gnt = w_gnt &  r_owner;
                end
                ST_RESP: begin
                    if (r_owner) begin
                        m1_rvalid = s_rvalid;
                        m1_rdata  = s_rdata;
                        m1_err    = s_err;
                    end else begin
                        m0_rvalid = s_rvalid;
                        m0_rdata  = s_rdata;
                        m0_err    = s_err;
                    end
                end
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
                ST_TERR: begin
                    if (r_owner) begin
                        m1_rvalid = 1'b1;
                        m1_err    = 1'b1;
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_err    = 1'b1;
                    end
                end
`endif
                default: begin
                    s_req = 1'b0;
                end
            endcase
        end else begin
            s_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed stimulus, a
// transaction-level reference model compared on every cycle, and literal
// expectations at the key points of each scenario.
module tb_periph_bus_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mi_req   [2];
    logic        mi_we    [2];
    logic [3:0]  mi_be    [2];
    logic [31:0] mi_addr  [2];
    logic [31:0] mi_wdata [2];
    logic        s_gnt = 1'b0, s_rvalid = 1'b0, s_err = 1'b0;
    logic [31:0] s_rdata = 32'h0;

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(mi_req[0]), .m0_we(mi_we[0]), .m0_be(mi_be[0]), .m0_addr(mi_addr[0]),
        .m0_wdata(mi_wdata[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(mi_req[1]), .m1_we(mi_we[1]), .m1_be(mi_be[1]), .m1_addr(mi_addr[1]),
        .m1_wdata(mi_wdata[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
    );

    // ---------------- reference model (transaction level) ----------------
    // md_busy: a transaction belongs to md_own; md_acc: slave accepted it;
    // md_terr: timeout error response is due this cycle; md_wait: ungranted REQ cycles.
    logic md_busy = 1'b0, md_acc = 1'b0, md_terr = 1'b0, md_own = 1'b0, md_last = 1'b1;
    int   md_wait = 0;
    logic tmo_now;
    logic        e_gnt [2], e_rv [2], e_er [2];
    logic [31:0] e_rd  [2];
    logic        e_sreq, e_swe;
    logic [3:0]  e_sbe;
    logic [31:0] e_saddr, e_swdata;

    // Expected outputs for the current cycle from model state and present inputs.
    always_comb begin
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
        tmo_now = (md_wait == TMO - 1) && !s_gnt;
`else
        tmo_now = 1'b0;
`endif
        e_sreq = 1'b0; e_swe = 1'b0; e_sbe = 4'h0; e_saddr = 32'h0; e_swdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            e_gnt[i] = 1'b0; e_rv[i] = 1'b0; e_er[i] = 1'b0; e_rd[i] = 32'h0;
        end
        if (rst && md_busy) begin
            if (md_terr) begin
                e_rv[md_own] = 1'b1;
                e_er[md_own] = 1'b1;
            end else if (md_acc) begin
                e_rv[md_own] = s_rvalid;
                e_rd[md_own] = s_rdata;
                e_er[md_own] = s_err;
            end else if (mi_req[md_own]) begin
                e_sreq   = 1'b1;
                e_swe    = mi_we[md_own];
                e_sbe    = mi_be[md_own];
                e_saddr  = mi_addr[md_own];
                e_swdata = mi_wdata[md_own];
                e_gnt[md_own] = s_gnt | tmo_now;
            end
        end
    end

    task automatic model_step();
        logic pick;
        pick = (mi_req[0] && mi_req[1]) ? ~md_last : mi_req[1];
        if (!rst) begin
            md_busy = 1'b0; md_acc = 1'b0; md_terr = 1'b0; md_own = 1'b0;
            md_last = 1'b1; md_wait = 0;
        end else if (!md_busy || md_terr || (md_acc && s_rvalid)) begin
            md_busy = mi_req[0] | mi_req[1];
            md_own  = pick;
            md_acc  = 1'b0; md_terr = 1'b0; md_wait = 0;
        end else if (!md_acc) begin
            if (!mi_req[md_own]) begin
                md_busy = 1'b0;
            end else if (s_gnt) begin
                md_acc = 1'b1; md_last = md_own;
            end else if (tmo_now) begin
                md_terr = 1'b1; md_last = md_own;
            end else begin
                md_wait = md_wait + 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk = n_chk + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Advance the model on each active edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare every DUT output against the model on each falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("m0_gnt",    32'(m0_gnt),    32'(e_gnt[0]));
            chk("m1_gnt",    32'(m1_gnt),    32'(e_gnt[1]));
            chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
            chk("m0_rdata",  m0_rdata,       e_rd[0]);
            chk("m1_rdata",  m1_rdata,       e_rd[1]);
            chk("m0_err",    32'(m0_err),    32'(e_er[0]));
            chk("m1_err",    32'(m1_err),    32'(e_er[1]));
            chk("s_req",     32'(s_req),     32'(e_sreq));
            chk("s_we",      32'(s_we),      32'(e_swe));
            chk("s_be",      32'(s_be),      32'(e_sbe));
            chk("s_addr",    s_addr,         e_saddr);
            chk("s_wdata",   s_wdata,        e_swdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mi_req[i] = 1'b0; mi_we[i] = 1'b0; mi_be[i] = 4'hF;
            mi_addr[i] = 32'h0; mi_wdata[i] = 32'h0;
        end
        s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0; s_rdata = 32'h0;
        adv();
        @(negedge clk);
        chk("rst_s_req", 32'(s_req), 32'd0);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        adv();
        rst = 1'b1;
    endtask

    initial begin
        int gnt_cyc;
        do_reset();

        // 1: m0 single read of 0x1000
        mi_req[0] = 1'b1; mi_addr[0] = 32'h0000_1000; s_gnt = 1'b1;
        @(negedge clk); chk("t1_c0_s_req", 32'(s_req), 32'd0); adv();
        @(negedge clk); chk("t1_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("t1_s_addr", s_addr, 32'h0000_1000); adv();
        mi_req[0] = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hA5A5_0001;
        @(negedge clk); chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t1_m0_rdata", m0_rdata, 32'hA5A5_0001);
        chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0); adv();
        s_rvalid = 1'b0;

        // 2: continuous contention after reset, strict alternation
        do_reset();
        mi_req[0] = 1'b1; mi_req[1] = 1'b1;
        mi_addr[0] = 32'h0000_0010; mi_addr[1] = 32'h0000_0020;
        @(negedge clk); adv();
        for (int k = 0; k < 4; k++) begin
            s_gnt = 1'b1; s_rvalid = 1'b0;
            @(negedge clk);
            chk("t2_gnt_m0", 32'(m0_gnt), 32'(k % 2 == 0));
            chk("t2_gnt_m1", 32'(m1_gnt), 32'(k % 2 == 1));
            adv();
            s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'(32'h100 + k);
            if (k == 3) begin
                mi_req[0] = 1'b0; mi_req[1] = 1'b0;
            end
            @(negedge clk);
            chk("t2_gap", 32'(s_req), 32'd0);
            chk("t2_rv_m0", 32'(m0_rvalid), 32'(k % 2 == 0));
            chk("t2_rv_m1", 32'(m1_rvalid), 32'(k % 2 == 1));
            adv();
        end
        s_rvalid = 1'b0;

        // 3: m1 write with error response
        mi_req[1] = 1'b1; mi_we[1] = 1'b1; mi_be[1] = 4'b0011;
        mi_addr[1] = 32'h0000_2000; mi_wdata[1] = 32'h1234_5678;
        @(negedge clk); adv();
        s_gnt = 1'b1;
        @(negedge clk); chk("t3_s_we", 32'(s_we), 32'd1);
        chk("t3_s_be", 32'(s_be), 32'h3); chk("t3_s_wdata", s_wdata, 32'h1234_5678);
        chk("t3_m1_gnt", 32'(m1_gnt), 32'd1); adv();
        mi_req[1] = 1'b0; mi_we[1] = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_err = 1'b1;
        @(negedge clk); chk("t3_m1_err", 32'(m1_err), 32'd1);
        chk("t3_m0_err", 32'(m0_err), 32'd0); adv();
        s_rvalid = 1'b0; s_err = 1'b0;

        // 4: slave stalls m0's grant while m1 waits
        mi_req[0] = 1'b1; mi_addr[0] = 32'h0000_3000;
        mi_req[1] = 1'b1; mi_addr[1] = 32'h0000_4000;
        @(negedge clk); adv();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("t4_m1_wait", 32'(m1_gnt), 32'd0);
            chk("t4_m0_wait", 32'(m0_gnt), 32'd0); adv();
        end
        s_gnt = 1'b1;
        @(negedge clk); chk("t4_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("t4_m1_gnt", 32'(m1_gnt), 32'd0); adv();
        mi_req[0] = 1'b0; s_gnt = 1'b0;
        @(negedge clk); chk("t4_m1_resp", 32'(m1_gnt), 32'd0); adv();
        s_rvalid = 1'b1; s_rdata = 32'hC0DE_0004;
        @(negedge clk); chk("t4_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t4_m1_rv_gnt", 32'(m1_gnt), 32'd0); adv();
        s_rvalid = 1'b0; s_gnt = 1'b1;
        @(negedge clk); chk("t4_m1_gnt_next", 32'(m1_gnt), 32'd1);
        chk("t4_s_addr", s_addr, 32'h0000_4000); adv();
        mi_req[1] = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hC0DE_0005;
        @(negedge clk); chk("t4_m1_rvalid", 32'(m1_rvalid), 32'd1); adv();
        s_rvalid = 1'b0;

        // 5: reset during RESP, late response dropped, m0 priority restored
        mi_req[0] = 1'b1; mi_addr[0] = 32'h0000_5000;
        @(negedge clk); adv();
        s_gnt = 1'b1;
        @(negedge clk); chk("t5_m0_gnt", 32'(m0_gnt), 32'd1); adv();
        mi_req[0] = 1'b0; s_gnt = 1'b0; rst = 1'b0;
        @(negedge clk); chk("t5_rst_rv", 32'(m0_rvalid), 32'd0); adv();
        s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0;
        @(negedge clk); chk("t5_rst_rv2", 32'(m0_rvalid), 32'd0);
        chk("t5_rst_rd", m0_rdata, 32'h0); adv();
        rst = 1'b1; mi_req[0] = 1'b1; mi_req[1] = 1'b1;
        @(negedge clk); chk("t5_idle_rv", 32'(m0_rvalid), 32'd0); adv();
        s_rvalid = 1'b0; s_gnt = 1'b1;
        @(negedge clk); chk("t5_prio_m0", 32'(m0_gnt), 32'd1);
        chk("t5_prio_m1", 32'(m1_gnt), 32'd0); adv();
        mi_req[0] = 1'b0; mi_req[1] = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0055;
        @(negedge clk); chk("t5_m0_rvalid", 32'(m0_rvalid), 32'd1); adv();
        s_rvalid = 1'b0;

        // 6: slave never grants m1
        mi_req[1] = 1'b1; mi_addr[1] = 32'h0000_6000; s_rdata = 32'hDEAD_BEEF;
        gnt_cyc = -1;
        for (int c = 0; c < 100 && gnt_cyc < 0; c++) begin
            @(negedge clk);
            if (m1_gnt) gnt_cyc = c;
            adv();
            if (gnt_cyc >= 0) mi_req[1] = 1'b0;
        end
`ifdef PERIPH_BUS_ARB_TIMEOUT_EN
        chk("t6_tmo_gnt_cycle", 32'(gnt_cyc), 32'(TMO));
        @(negedge clk); chk("t6_terr_rv", 32'(m1_rvalid), 32'd1);
        chk("t6_terr_err", 32'(m1_err), 32'd1); chk("t6_terr_rd", m1_rdata, 32'h0); adv();
`else
        chk("t6_no_gnt", 32'(gnt_cyc), 32'hFFFF_FFFF);
        mi_req[1] = 1'b0;
        @(negedge clk); chk("t6_abandon", 32'(s_req), 32'd0); adv();
`endif
        @(negedge clk); chk("t6_idle", 32'(s_req), 32'd0); adv();
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
